// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a small byte FIFO on a valid/ready push interface.
// State | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops the next byte straight into START if one is queued
module uart_tx_serializer #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_FW  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_nxt;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   baud_cnt, baud_cnt_nxt;
    logic [2:0]         bit_idx, bit_idx_nxt;
    logic [7:0]         shift, shift_nxt;
    logic [CNT_FW-1:0]  count_nxt;
    logic               uart_tx_nxt;
    logic               tx_busy_nxt;
    logic               push, pop, baud_tc;

    assign tx_ready = (fifo_count != CNT_FW'(FIFO_DEPTH));
    assign push     = tx_valid && tx_ready;
    assign baud_tc  = (baud_cnt == '0);

    // Baud timer is a down-counter reloaded with DIVISOR-1 on every bit boundary.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift;
        uart_tx_nxt  = uart_tx;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                uart_tx_nxt = 1'b1;
                if (fifo_count != '0) begin
                    pop          = 1'b1;
                    shift_nxt    = mem[rd_ptr];
                    state_nxt    = START;
                    baud_cnt_nxt = CNT_W'(DIVISOR - 1);
                    uart_tx_nxt  = 1'b0;
                end
            end
            START: begin
                if (baud_tc) begin
                    state_nxt    = DATA;
                    bit_idx_nxt  = 3'd0;
                    baud_cnt_nxt = CNT_W'(DIVISOR - 1);
                    uart_tx_nxt  = shift[0];
                end else begin
                    baud_cnt_nxt = baud_cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_tc) begin
                    baud_cnt_nxt = CNT_W'(DIVISOR - 1);
                    if (bit_idx == 3'd7) begin
                        state_nxt   = STOP;
                        uart_tx_nxt = 1'b1;
                    end else begin
                        shift_nxt   = {1'b0, shift[7:1]};
                        bit_idx_nxt = bit_idx + 3'd1;
                        uart_tx_nxt = shift[1];
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_tc) begin
                    if (fifo_count != '0) begin
                        pop          = 1'b1;
                        shift_nxt    = mem[rd_ptr];
                        state_nxt    = START;
                        baud_cnt_nxt = CNT_W'(DIVISOR - 1);
                        uart_tx_nxt  = 1'b0;
                    end else begin
                        state_nxt   = IDLE;
                        uart_tx_nxt = 1'b1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                uart_tx_nxt = 1'b1;
            end
        endcase

        case ({push, pop})
            2'b10:   count_nxt = fifo_count + CNT_FW'(1);
            2'b01:   count_nxt = fifo_count - CNT_FW'(1);
            default: count_nxt = fifo_count;
        endcase
        tx_busy_nxt = (state_nxt != IDLE) || (count_nxt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            uart_tx    <= 1'b1;
            tx_busy    <= 1'b0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift      <= shift_nxt;
            uart_tx    <= uart_tx_nxt;
            tx_busy    <= tx_busy_nxt;
            fifo_count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end
endmodule
